// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the RV32I multi-cycle datapath: steps IF/ID/EX/MEM/WB,
// drives every datapath select/enable, and flags ECALL halt and memory timeouts.
module multicycle_control_fsm #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       x17_is_10,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       is_halted,
  output logic       mem_error,
  output logic [2:0] state
);

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_BR   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             timeout;
  logic             known_op;

  assign state   = state_q;
  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT));

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_ARITH, OP_ARITH_IMM, OP_LOAD,
      OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known_op = 1'b1;
      default:                                         known_op = 1'b0;
    endcase
  end

  // Next state and all datapath controls; unlisted controls stay 0.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    is_halted    = (state_q == S_HALT) || (state_q == S_ERR);
    mem_error    = (state_q == S_ERR);

    case (state_q)
      S_IF: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          // A fetch completing while reset is held must not disturb IR.
          ir_write = reset;
          state_d  = S_ID;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_ID: begin
        if (opcode == OP_ECALL && x17_is_10) begin
          state_d = S_HALT;
        end else if (opcode == OP_ECALL || !known_op) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1; alu_src_b = 2'd0; alu_op = 2'd2; state_d = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd2; state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd0; state_d = S_MEM;
          end
          OP_AUIPC: begin
            alu_src_a = 1'b0; alu_src_b = 2'd2; alu_op = 2'd0; state_d = S_WB;
          end
          OP_LUI: state_d = S_WB;
          OP_JAL: begin
            alu_src_a = 1'b0; alu_src_b = 2'd2; alu_op = 2'd0;
            pc_write  = 1'b1; pc_src = 2'd0; state_d = S_WB;
          end
          OP_JALR: begin
            alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd0;
            pc_write  = 1'b1; pc_src = 2'd0; state_d = S_WB;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1; alu_src_b = 2'd0; alu_op = 2'd1;
            if (bcond) begin
              state_d = S_BR;
            end else begin
              pc_write = 1'b1; pc_src = 2'd2; state_d = S_IF;
            end
          end
          default: begin
            pc_write = 1'b1; pc_src = 2'd2; state_d = S_IF;
          end
        endcase
      end

      // Taken branch: ALU recomputes PC-relative target.
      S_BR: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'd2;
        alu_op    = 2'd0;
        pc_write  = 1'b1;
        pc_src    = 2'd0;
        state_d   = S_IF;
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write    = (opcode == OP_STORE);
        mem_read     = (opcode != OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1; pc_src = 2'd2; state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        case (opcode)
          OP_LOAD:          wb_sel = 2'd1;
          OP_LUI:           wb_sel = 2'd2;
          OP_JAL, OP_JALR:  wb_sel = 2'd3;
          default:          wb_sel = 2'd0;
        endcase
        if (opcode != OP_JAL && opcode != OP_JALR) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
        state_d = S_IF;
      end

      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
    endcase
  end

  // Stall counter: counts unanswered memory cycles within one IF/MEM visit.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == S_IF || state_q == S_MEM) && !mem_ready && state_d == state_q)
      wait_cnt_d = wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IF;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instruction-level plans expand into
// per-cycle expected control vectors, checked by an independent monitor.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] FENCE = 7'b0001111;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_read, mem_write, mem_addr_sel, ir_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       is_halted, mem_error;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       bc, x17, rdy;
    exp_t       e;
    string      tag;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic bcond = 1'b0, x17_is_10 = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_read, mem_write, mem_addr_sel, ir_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, wb_sel, pc_src;
  logic reg_write, pc_write, is_halted, mem_error;
  logic [2:0] state;

  int tests = 0;
  int failed = 0;
  cyc_t plan[$];
  cyc_t sb[$];

  multicycle_control_fsm #(.MAX_WAIT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17_is_10(x17_is_10),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .pc_write(pc_write), .pc_src(pc_src), .is_halted(is_halted), .mem_error(mem_error),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t blank(input int st);
    exp_t e = '0;
    e.st = 3'(st);
    e.is_halted = (st == 6 || st == 7);
    e.mem_error = (st == 7);
    return e;
  endfunction

  // Don't-care inputs are randomized every cycle.
  function automatic cyc_t rnd(input logic [6:0] op);
    cyc_t c;
    c.rst = 1'b1;
    c.op  = op;
    c.bc  = 1'($urandom);
    c.x17 = 1'($urandom);
    c.rdy = 1'($urandom);
    c.e   = '0;
    c.tag = "";
    return c;
  endfunction

  function automatic exp_t fetch_exp(input logic done);
    exp_t e = blank(0);
    e.mem_req = 1'b1;
    e.mem_read = 1'b1;
    e.ir_write = done;
    return e;
  endfunction

  // One instruction from the ISA's point of view; keep<0 keeps every cycle.
  task automatic add_instr(input logic [6:0] op, input logic bc, input logic x17,
                           input int if_wait, input int mem_wait, input int keep);
    cyc_t seq[$];
    cyc_t c;
    exp_t e;
    bit do_mem, do_wb, done;
    do_mem = 0; do_wb = 0; done = 0;
    for (int i = 0; i <= if_wait; i++) begin
      c = rnd(op); c.rdy = (i == if_wait); c.e = fetch_exp(c.rdy); c.tag = "fetch";
      seq.push_back(c);
    end
    c = rnd(op); c.x17 = x17; e = blank(1); c.tag = "decode";
    if (op == ECALL && x17) begin
      done = 1;
    end else if (op == ECALL || !(op inside {LUI, AUIPC, ADD, ADDI, LW, SW, BEQ, JAL, JALR})) begin
      e.pc_write = 1; e.pc_src = 2; done = 1;
    end
    c.e = e; seq.push_back(c);
    if (!done) begin
      c = rnd(op); e = blank(2); c.tag = "execute";
      case (op)
        ADD:     begin e.alu_src_a = 1; e.alu_src_b = 0; e.alu_op = 2; do_wb = 1; end
        ADDI:    begin e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 2; do_wb = 1; end
        LW, SW:  begin e.alu_src_a = 1; e.alu_src_b = 2; do_mem = 1; end
        AUIPC:   begin e.alu_src_b = 2; do_wb = 1; end
        LUI:     do_wb = 1;
        JAL:     begin e.alu_src_b = 2; e.pc_write = 1; do_wb = 1; end
        JALR:    begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; do_wb = 1; end
        default: begin
          e.alu_src_a = 1; e.alu_op = 1; c.bc = bc;
          if (!bc) begin e.pc_write = 1; e.pc_src = 2; end
        end
      endcase
      c.e = e; seq.push_back(c);
      if (op == BEQ && bc) begin
        c = rnd(op); e = blank(3); e.alu_src_b = 2; e.pc_write = 1; c.e = e; c.tag = "branch";
        seq.push_back(c);
      end
      if (do_mem) begin
        for (int i = 0; i <= mem_wait; i++) begin
          c = rnd(op); c.rdy = (i == mem_wait); e = blank(4); c.tag = "memory";
          e.mem_req = 1; e.mem_addr_sel = 1;
          e.mem_read = (op == LW); e.mem_write = (op == SW);
          if (c.rdy && op == SW) begin e.pc_write = 1; e.pc_src = 2; end
          c.e = e; seq.push_back(c);
        end
        do_wb = (op == LW);
      end
      if (do_wb) begin
        c = rnd(op); e = blank(5); e.reg_write = 1; c.tag = "writeback";
        e.wb_sel = (op == LW) ? 2'd1 : (op == LUI) ? 2'd2 : (op == JAL || op == JALR) ? 2'd3 : 2'd0;
        if (op != JAL && op != JALR) begin e.pc_write = 1; e.pc_src = 2; end
        c.e = e; seq.push_back(c);
      end
    end
    for (int i = 0; i < seq.size(); i++)
      if (keep < 0 || i < keep) plan.push_back(seq[i]);
  endtask

  task automatic add_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = rnd(7'($urandom)); c.rst = 1'b0; c.e = fetch_exp(1'b0); c.tag = "reset";
      plan.push_back(c);
    end
  endtask

  task automatic add_terminal(input int st, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = rnd(7'($urandom)); c.e = blank(st); c.tag = (st == 6) ? "halt" : "error";
      plan.push_back(c);
    end
  endtask

  // Fetch that never completes: 16 stalled IF cycles, then ERR.
  task automatic add_fetch_timeout(input int n_after);
    cyc_t c;
    for (int i = 0; i < 16; i++) begin
      c = rnd(ADDI); c.rdy = 1'b0; c.e = fetch_exp(1'b0); c.tag = "fetch_stall";
      plan.push_back(c);
    end
    add_terminal(7, n_after);
  endtask

  initial begin : drive
    logic [6:0] ops[11];
    logic [6:0] op;
    ops = '{LUI, AUIPC, ADD, ADDI, LW, SW, BEQ, JAL, JALR, ECALL, FENCE};

    add_reset(3);
    add_instr(ADDI, 0, 0, 0, 0, -1);
    add_instr(LW,   0, 0, 0, 3, -1);
    add_instr(BEQ,  0, 0, 0, 0, -1);
    add_instr(BEQ,  1, 0, 0, 0, -1);
    add_instr(JAL,  0, 0, 0, 0, -1);
    add_instr(JALR, 0, 0, 1, 0, -1);
    add_instr(LUI,  0, 0, 0, 0, -1);
    add_instr(AUIPC,0, 0, 2, 0, -1);
    add_instr(ADD,  0, 0, 0, 0, -1);
    add_instr(SW,   0, 0, 0, 2, -1);
    add_instr(FENCE,0, 0, 0, 0, -1);
    add_instr(ECALL,0, 0, 0, 0, -1);
    add_instr(ADDI, 0, 0, 15, 0, -1);
    add_instr(LW,   0, 0, 0, 15, -1);
    add_instr(SW,   0, 0, 15, 15, -1);
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 10)];
      add_instr(op, 1'($urandom), 1'b0,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4)), -1);
    end
    add_instr(LW, 0, 0, 0, 6, 6);
    add_reset(2);
    add_instr(ADDI, 0, 0, 15, 0, -1);
    add_instr(ECALL, 0, 1, 0, 0, -1);
    add_terminal(6, 20);
    add_reset(2);
    add_fetch_timeout(5);
    add_reset(2);
    add_instr(ADD, 0, 0, 0, 0, -1);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset     = plan[i].rst;
      opcode    = plan[i].op;
      bcond     = plan[i].bc;
      x17_is_10 = plan[i].x17;
      mem_ready = plan[i].rdy;
      sb.push_back(plan[i]);
    end
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : monitor
    cyc_t c;
    exp_t got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        c = sb.pop_front();
        got = exp_t'({state, mem_req, mem_read, mem_write, mem_addr_sel, ir_write, alu_src_a,
                      alu_src_b, alu_op, reg_write, wb_sel, pc_write, pc_src, is_halted, mem_error});
        tests++;
        if (got !== c.e) begin
          failed++;
          $display("FAIL %s @%0t: got st=%0d ctrl=%h, want st=%0d ctrl=%h",
                   c.tag, $time, got.st, got, c.e.st, c.e);
        end
      end
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the RV32I multi-cycle datapath: steps each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable: ALU operand muxes, immediate-fed ALU ops, memory request/handshake, register-file write, PC update.
- Takes the IR opcode, the ALU branch condition and a memory ready signal.
- Detects the ECALL halt condition and memory timeouts.

Parameters:
- MAX_WAIT, 15, maximum consecutive IF/MEM cycles with mem_req=1 and mem_ready=0 before the controller enters ERR.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction[6:0] from IR; stable from ID onward.
- bcond  input  1  ALU branch-compare result; valid in EX when alu_op=1.
- x17_is_10  input  1  register x17 == 10; sampled in ID.
- mem_ready  input  1  memory completes the current request this cycle; may assert in the first request cycle.
- mem_req  output  1  memory access active.
- mem_read  output  1  read request.
- mem_write  output  1  write request.
- mem_addr_sel  output  1  memory address source: 0 PC, 1 ALUOut.
- ir_write  output  1  latch fetched word into IR and the current PC into old_pc.
- alu_src_a  output  1  ALU operand A: 0 PC, 1 rs1.
- alu_src_b  output  2  ALU operand B: 0 rs2, 2 immediate; 1 and 3 unused.
- alu_op  output  2  ALU function: 0 add, 1 branch compare, 2 funct-decoded.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  writeback source: 0 ALUOut, 1 MDR, 2 immediate, 3 old_pc+4.
- pc_write  output  1  PC update enable.
- pc_src  output  2  next PC: 0 ALU result (this cycle), 2 old_pc+4.
- is_halted  output  1  controller is in HALT or ERR.
- mem_error  output  1  controller is in ERR.
- state  output  3  current state, debug.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, BR=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (reset=0, asynchronous): state=IF, wait_cnt=0.
- All outputs decode combinationally from state and opcode; any output not listed for a state is 0.
- Consequence of reset: while reset is held, mem_req=1, mem_read=1 and all other outputs are 0. Reset asserted mid-instruction aborts it with no further enables.
- Opcodes: LUI 0110111, AUIPC 0010111, ARITH 0110011, ARITH_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- IF:
  - mem_req=1, mem_read=1, mem_addr_sel=0.
  - On mem_ready: ir_write=1, next state ID.
- ID:
  - ECALL with x17_is_10=1: next state HALT.
  - ECALL with x17_is_10=0: pc_write=1, pc_src=2, next state IF.
  - Unknown opcode: treated as NOP; pc_write=1, pc_src=2, next state IF.
  - All other opcodes: next state EX.
- EX, by opcode:
  - ARITH: a=1, b=0, op=2; next WB.
  - ARITH_IMM: a=1, b=2, op=2; next WB.
  - LOAD/STORE: a=1, b=2, op=0; next MEM.
  - AUIPC: a=0, b=2, op=0; next WB.
  - LUI: no ALU use; next WB.
  - JAL: a=0, b=2, op=0, pc_write=1, pc_src=0; next WB.
  - JALR: a=1, b=2, op=0, pc_write=1, pc_src=0; next WB.
  - BRANCH: a=1, b=0, op=1. If bcond=0: pc_write=1, pc_src=2, next IF. If bcond=1: next BR.
- BR: a=0, b=2, op=0, pc_write=1, pc_src=0; next IF.
- MEM:
  - mem_req=1, mem_addr_sel=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - On mem_ready, LOAD: next WB.
  - On mem_ready, STORE: pc_write=1, pc_src=2, next IF.
- WB:
  - reg_write=1.
  - wb_sel: 1 for LOAD, 2 for LUI, 3 for JAL/JALR, 0 otherwise.
  - Non-jump opcodes: pc_write=1, pc_src=2.
  - Next state IF.
- Wait counter:
  - Increments each IF/MEM cycle with mem_ready=0.
  - Clears on mem_ready and on any state change.
  - When wait_cnt==MAX_WAIT and mem_ready=0: next state ERR.
  - mem_ready in that same cycle wins; normal transition, no error.
- HALT/ERR:
  - Terminal until reset; all enables 0.
  - is_halted=1 in both; mem_error=1 only in ERR.
- Latency with zero-wait memory:
  - ARITH/ARITH_IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles not-taken, 4 cycles taken.
- Each memory wait cycle adds 1 cycle in IF or MEM.
- pc_write asserts exactly once per instruction.
- reg_write asserts at most once per instruction.

Test Plan:
- Release reset, mem_ready=1 always, ADDI (0010011) -> state sequence 0,1,2,5,0; in EX a=1, b=2, op=2; in WB reg_write=1, wb_sel=0, pc_write=1, pc_src=2.
- LW with mem_ready low for 3 MEM cycles -> MEM held 4 cycles, mem_read=1, mem_addr_sel=1; WB wb_sel=1; 8 cycles total.
- BEQ with bcond=0 -> IF,ID,EX then IF, pc_src=2. Same with bcond=1 -> BR with pc_src=0, a=0, b=2; exactly one pc_write per instruction.
- JAL -> pc_write in EX with pc_src=0; WB reg_write=1, wb_sel=3, pc_write=0.
- ECALL with x17_is_10=1 -> HALT, is_halted=1, all enables 0 for 20 cycles. ECALL with x17_is_10=0 -> IF with pc_src=2.
- mem_ready held 0 in IF -> ERR after 16 IF cycles, mem_error=1. Repeat with mem_ready=1 in the 16th cycle -> ID, no error. Reset asserted mid-MEM -> immediate return to IF, wait_cnt=0.
